// File: rtl/simple_counter.sv
// Free-running up-counter with synchronous active-high clear.
// Define SIMPLE_COUNTER_SAT_EN to hold at MAX_COUNT instead of wrapping.
module simple_counter #(
  parameter int unsigned      WIDTH     = 4,
  parameter longint unsigned  MAX_COUNT = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  localparam longint unsigned LIMIT = (64'd1 << WIDTH) - 64'd1;

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("simple_counter: WIDTH %0d outside 1..32", WIDTH);
    end
    if (MAX_COUNT < 1 || MAX_COUNT > LIMIT) begin : g_bad_max
      $error("simple_counter: MAX_COUNT %0d out of range", MAX_COUNT);
    end
  endgenerate

  localparam logic [WIDTH-1:0] TERM = MAX_COUNT[WIDTH-1:0];

  logic [WIDTH-1:0] count_q;
  logic             at_term;

  assign at_term = (count_q == TERM);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (at_term) begin
`ifdef SIMPLE_COUNTER_SAT_EN
      count_q <= TERM;
`else
      count_q <= '0;
`endif
    end else begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_simple_counter.sv
// Scoreboard bench for simple_counter: directed plan then random resets,
// expected values from an edges-since-reset model.
module tb_simple_counter;

  localparam int W    = 4;
  localparam int MAXC = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] count;

  int checks   = 0;
  int failures = 0;

  int q[$];
  int since = -1;

  simple_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .count (count)
  );

  always #5 clk = ~clk;

  // Value after the next edge, from edges elapsed since the last reset.
  function automatic int model(int n);
`ifdef SIMPLE_COUNTER_SAT_EN
    return (n > MAXC) ? MAXC : n;
`else
    return n % (MAXC + 1);
`endif
  endfunction

  task automatic push(bit r);
    reset = r;
    if (r) since = 0;
    else if (since >= 0) since = since + 1;
    if (since >= 0) q.push_back(model(since));
  endtask

  task automatic step(bit r);
    @(negedge clk);
    push(r);
  endtask

  function automatic int cur();
    return (since < 0) ? -1 : model(since);
  endfunction

  initial begin : monitor
    int exp;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp = q.pop_front();
        checks++;
        if (count !== exp[W-1:0]) begin
          failures++;
          $display("FAIL count t=%0t got=%0d exp=%0d", $time, count, exp);
        end
      end
    end
  end

  initial begin : stim
    int guard;
    push(1'b1);
    step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0);
    for (int i = 0; i < 20; i++) step(1'b0);
    guard = 0;
    while (cur() != MAXC && guard < 40) begin
      step(1'b0);
      guard++;
    end
    step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    for (int i = 0; i < 22; i++) step(1'b0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 15) == 0);
    step(1'b1);
    for (int i = 0; i < 20; i++) step(1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
